// File: rtl/serdes_tx_framer_if.sv
// Source-side handshake bundle for the SerDes transmit framer.
// Sources drive request/valid/data; the framer drives read enables.
interface serdes_tx_framer_if #(
  parameter int NSRC  = 2,
  parameter int LANES = 4
);
  logic [NSRC-1:0]          I_src_req;
  logic [NSRC-1:0]          O_src_rd;
  logic [NSRC-1:0]          I_src_valid;
  logic [NSRC*LANES*16-1:0] I_src_dat;

  modport master (
    output I_src_req,
    output I_src_valid,
    output I_src_dat,
    input  O_src_rd
  );

  modport slave (
    input  I_src_req,
    input  I_src_valid,
    input  I_src_dat,
    output O_src_rd
  );
endinterface

// File: rtl/serdes_tx_framer.sv
// Multi-source SerDes transmit framer: arbitrates source bursts and
// wraps each in K-character header/trailer words with per-source seq.
module serdes_tx_framer #(
  parameter int LANES    = 4,
  parameter int NSRC     = 2,
  parameter int BURST    = 8,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 16
) (
  input  logic                  I_sys_clk,
  input  logic                  I_rst,
  serdes_tx_framer_if.slave     src,
  output logic [LANES*16-1:0]   O_tx_dat,
  output logic [LANES*2-1:0]    O_tx_is_k,
  output logic                  O_busy,
  output logic [3:0]            O_grant_id,
  output logic                  O_err
);

  localparam int W  = LANES * 16;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [15:0] W_IDLE = 16'hC5BC;
  localparam logic [7:0]  BURST8 = 8'(BURST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF1,
    S_SOF2,
    S_PAY,
    S_EOF
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      id_q, id_d;
  logic [3:0]      ptr_q, ptr_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      rdc_q, rdc_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      seq_q [NSRC];
  logic [7:0]      seq_d [NSRC];
  logic [W-1:0]    dat_q, dat_d;
  logic [LANES*2-1:0] k_q, k_d;
  logic [NSRC-1:0] rd_q, rd_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic            gnt_ok;
  logic [3:0]      gnt_id;
  logic [3:0]      gnt_nxt;
  logic [4:0]      base;
  logic [4:0]      sum;
  logic [4:0]      nxt;
  logic [2*NSRC-1:0] req2;

  logic            cur_v;
  logic [W-1:0]    cur_d;
  logic [7:0]      cur_seq;

  logic [15:0]     word;
  logic            pay;
  logic            counting;

  // Pick the next source: rotate the request vector to the search start.
  always_comb begin
    gnt_ok  = 1'b0;
    gnt_id  = 4'd0;
    sum     = 5'd0;
    base    = (ARB_MODE == 1) ? 5'd0 : {1'b0, ptr_q};
    req2    = {src.I_src_req, src.I_src_req} >> base;
    for (int k = 0; k < NSRC; k++) begin
      if (!gnt_ok && req2[k]) begin
        gnt_ok = 1'b1;
        sum    = base + 5'(k);
        if (sum >= 5'(NSRC)) sum = sum - 5'(NSRC);
        gnt_id = sum[3:0];
      end
    end
    nxt = {1'b0, gnt_id} + 5'd1;
    if (nxt >= 5'(NSRC)) nxt = 5'd0;
    gnt_nxt = nxt[3:0];
  end

  // Mux out the granted source's valid, data and sequence number.
  always_comb begin
    cur_v   = 1'b0;
    cur_d   = '0;
    cur_seq = 8'd0;
    for (int i = 0; i < NSRC; i++) begin
      if (id_q == 4'(i)) begin
        cur_v   = src.I_src_valid[i];
        cur_d   = src.I_src_dat[i*W +: W];
        cur_seq = seq_q[i];
      end
    end
  end

  // Frame sequencing, read issue, timeout and next output word.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    rdc_d    = rdc_q;
    tmo_d    = tmo_q;
    seq_d    = seq_q;
    rd_d     = '0;
    busy_d   = 1'b1;
    err_d    = 1'b0;
    word     = W_IDLE;
    pay      = 1'b0;
    counting = (rdc_q == BURST8);

    if (state_q != S_IDLE && state_q != S_EOF &&
        rdc_q < BURST8) begin
      rd_d  = NSRC'(1) << id_q;
      rdc_d = rdc_q + 8'd1;
    end

    unique case (state_q)
      S_IDLE, S_EOF: begin
        if (gnt_ok) begin
          state_d = S_SOF1;
          id_d    = gnt_id;
          ptr_d   = gnt_nxt;
          cnt_d   = 8'd0;
          rdc_d   = 8'd1;
          tmo_d   = '0;
          rd_d    = NSRC'(1) << gnt_id;
          word    = {8'hA0 | {4'h0, gnt_id}, 8'h3C};
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_SOF1: begin
        state_d = S_SOF2;
        word    = {cur_seq, 8'h1C};
        if (counting) tmo_d = tmo_q + TW'(1);
      end
      S_SOF2, S_PAY: begin
        if (state_q == S_PAY && cnt_q == BURST8) begin
          state_d = S_EOF;
          rd_d    = '0;
          word    = {BURST8, 8'h7C};
          for (int i = 0; i < NSRC; i++) begin
            if (id_q == 4'(i)) seq_d[i] = seq_q[i] + 8'd1;
          end
        end else if (cur_v && cnt_q < BURST8) begin
          state_d = S_PAY;
          pay     = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          tmo_d   = '0;
        end else if (counting &&
                     tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = S_EOF;
          rd_d    = '0;
          err_d   = 1'b1;
          word    = {cnt_q, 8'h5C};
        end else begin
          state_d = S_PAY;
          if (counting) tmo_d = tmo_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    dat_d = pay ? cur_d : {LANES{word}};
    k_d   = pay ? '0 : {LANES{2'b01}};
  end

  // State and registered outputs; reset drops any frame in flight.
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      state_q <= S_IDLE;
      id_q    <= 4'd0;
      ptr_q   <= 4'd0;
      cnt_q   <= 8'd0;
      rdc_q   <= 8'd0;
      tmo_q   <= '0;
      seq_q   <= '{default: 8'd0};
      dat_q   <= {LANES{W_IDLE}};
      k_q     <= {LANES{2'b01}};
      rd_q    <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rdc_q   <= rdc_d;
      tmo_q   <= tmo_d;
      seq_q   <= seq_d;
      dat_q   <= dat_d;
      k_q     <= k_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign src.O_src_rd = rd_q;
  assign O_tx_dat     = dat_q;
  assign O_tx_is_k    = k_q;
  assign O_busy       = busy_q;
  assign O_grant_id   = id_q;
  assign O_err        = err_q;

endmodule

// File: tb/tb_serdes_tx_framer.sv
// Self-checking bench for serdes_tx_framer: round-robin instance with
// stall/abort/reset scenarios plus a fixed-priority instance for seq wrap.
module tb_serdes_tx_framer;

  localparam int LANES   = 4;
  localparam int NSRC    = 2;
  localparam int BURST   = 8;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst;

  serdes_tx_framer_if #(.NSRC(NSRC), .LANES(LANES)) sa ();
  serdes_tx_framer_if #(.NSRC(NSRC), .LANES(LANES)) sb ();

  logic [63:0] dat_a, dat_b;
  logic [7:0]  k_a, k_b;
  logic        busy_a, busy_b, err_a, err_b;
  logic [3:0]  gid_a, gid_b;

  serdes_tx_framer #(
    .LANES(LANES), .NSRC(NSRC), .BURST(BURST),
    .ARB_MODE(0), .TIMEOUT(TIMEOUT)
  ) dut_rr (
    .I_sys_clk (clk),
    .I_rst     (rst),
    .src       (sa.slave),
    .O_tx_dat  (dat_a),
    .O_tx_is_k (k_a),
    .O_busy    (busy_a),
    .O_grant_id(gid_a),
    .O_err     (err_a)
  );

  serdes_tx_framer #(
    .LANES(LANES), .NSRC(NSRC), .BURST(BURST),
    .ARB_MODE(1), .TIMEOUT(TIMEOUT)
  ) dut_fp (
    .I_sys_clk (clk),
    .I_rst     (rst),
    .src       (sb.slave),
    .O_tx_dat  (dat_b),
    .O_tx_is_k (k_b),
    .O_busy    (busy_b),
    .O_grant_id(gid_b),
    .O_err     (err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  bit          sel;
  bit          flush;
  bit          stall_a [2];
  int          budget_a [2];
  logic [31:0] seed_a [2];
  int          pend_a [2];
  int          k_ga [2];
  int          pend_b [2];
  int          exp_k [2];
  int          seq_m [2];
  int          ptr_m;

  logic [63:0] m_dat;
  logic [7:0]  m_k;
  logic [1:0]  m_rd;
  logic        m_busy, m_err;
  logic [3:0]  m_gid;

  assign m_dat  = sel ? dat_b  : dat_a;
  assign m_k    = sel ? k_b    : k_a;
  assign m_rd   = sel ? sb.O_src_rd : sa.O_src_rd;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_err  = sel ? err_b  : err_a;
  assign m_gid  = sel ? gid_b  : gid_a;

  function automatic logic [63:0] mix(input logic [31:0] sd,
                                      input int k);
    return {sd + 32'(k) * 32'h9E3779B1,
            sd ^ (32'(k) * 32'h85EBCA6B) ^ 32'h1};
  endfunction

  function automatic logic [63:0] rep(input logic [15:0] w);
    return {4{w}};
  endfunction

  // Source A: FIFO with 1-cycle latency; honours stall and word budget.
  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      int p;
      bit give;
      p = pend_a[s] + int'(sa.O_src_rd[s]);
      give = (p > 0) && !stall_a[s] && (k_ga[s] < budget_a[s]);
      if (rst || flush) begin
        pend_a[s] <= 0;
        k_ga[s]   <= 0;
        sa.I_src_valid[s] <= 1'b0;
      end else begin
        sa.I_src_valid[s] <= give;
        if (give) begin
          sa.I_src_dat[s*64 +: 64] <= mix(seed_a[s], k_ga[s]);
          k_ga[s]   <= k_ga[s] + 1;
          pend_a[s] <= p - 1;
        end else begin
          pend_a[s] <= p;
        end
      end
    end
  end

  // Source B: always returns data one cycle after each read.
  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      int p;
      p = pend_b[s] + int'(sb.O_src_rd[s]);
      if (rst) begin
        pend_b[s] <= 0;
        sb.I_src_valid[s] <= 1'b0;
      end else begin
        sb.I_src_valid[s] <= (p > 0);
        pend_b[s] <= (p > 0) ? p - 1 : 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [71:0] obs,
                     input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [1:0] r);
    for (int k = 0; k < 2; k++) begin
      int s;
      s = (ptr_m + k) % 2;
      if (r[s]) return s;
    end
    return 0;
  endfunction

  // Called at the negedge where SOF1 must appear; returns at trailer.
  task automatic capture(input int id, input int sq, input int n_exp,
                         input int idl_exp, input bit abort,
                         input bit drop);
    int  n;
    int  idl;
    int  cyc;
    bit  done;
    n = 0; idl = 0; cyc = 0; done = 1'b0;
    chk("sof1", {m_dat, m_k},
        {rep({8'hA0 | 8'(id), 8'h3C}), 8'h55});
    chk("grant_id", 72'(m_gid), 72'(id));
    chk("busy_sof", 72'(m_busy), 72'(1));
    chk("rd_sof", 72'(m_rd), 72'(1 << id));
    if (drop) begin
      if (sel) sb.I_src_req = 2'b00;
      else     sa.I_src_req = 2'b00;
    end
    @(negedge clk);
    chk("sof2", {m_dat, m_k}, {rep({8'(sq), 8'h1C}), 8'h55});
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (m_k == 8'h00) begin
        if (!sel) chk("payload", 72'(m_dat), 72'(mix(seed_a[id], exp_k[id])));
        exp_k[id]++;
        n++;
      end else if ({m_dat, m_k} == {rep(16'hC5BC), 8'h55}) begin
        idl++;
      end else begin
        done = 1'b1;
      end
    end
    chk("trailer_bound", 72'(done), 72'(1));
    if (abort) begin
      chk("abort_word", {m_dat, m_k}, {rep({8'(n_exp), 8'h5C}), 8'h55});
      chk("err_abort", 72'(m_err), 72'(1));
    end else begin
      chk("eof_word", {m_dat, m_k}, {rep({8'(BURST), 8'h7C}), 8'h55});
      chk("err_eof", 72'(m_err), 72'(0));
    end
    chk("busy_trl", 72'(m_busy), 72'(1));
    chk("pay_count", 72'(n), 72'(n_exp));
    chk("idle_count", 72'(idl), 72'(idl_exp));
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {m_dat, m_k}, {rep(16'hC5BC), 8'h55});
    chk({tag, "_busy"}, 72'(m_busy), 72'(0));
  endtask

  initial begin
    int g;
    rst = 1'b1;
    sel = 1'b0;
    flush = 1'b0;
    sa.I_src_req = 2'b00;
    sb.I_src_req = 2'b00;
    sb.I_src_dat = '0;
    ptr_m = 0;
    for (int s = 0; s < 2; s++) begin
      stall_a[s]  = 1'b0;
      budget_a[s] = 1000;
      seed_a[s]   = $urandom;
      exp_k[s]    = 0;
      seq_m[s]    = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_dat", 72'(dat_a), 72'(rep(16'hC5BC)));
    chk("rst_isk", 72'(k_a), 72'(8'h55));
    chk("rst_rd", 72'(sa.O_src_rd), 72'(0));
    chk("rst_busy", 72'(busy_a), 72'(0));
    chk("rst_gid", 72'(gid_a), 72'(0));
    chk("rst_err", 72'(err_a), 72'(0));
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Single frame from source 0.
    sa.I_src_req = 2'b01;
    g = pick(2'b01);
    ptr_m = (g + 1) % 2;
    @(negedge clk);
    capture(g, seq_m[g], BURST, 0, 1'b0, 1'b1);
    seq_m[g]++;
    @(negedge clk);
    chk_idle("idle_after1");
    chk("gid_hold", 72'(gid_a), 72'(0));

    // Round-robin, both requesting: back-to-back frames.
    sa.I_src_req = 2'b11;
    @(negedge clk);
    for (int f = 0; f < 4; f++) begin
      g = pick(2'b11);
      ptr_m = (g + 1) % 2;
      capture(g, seq_m[g], BURST, 0, 1'b0, f == 3);
      seq_m[g]++;
      if (f < 3) @(negedge clk);
    end
    @(negedge clk);
    chk_idle("idle_after_rr");

    // Source stalls valid for three cycles mid-burst.
    sa.I_src_req = 2'b01;
    g = pick(2'b01);
    ptr_m = (g + 1) % 2;
    @(negedge clk);
    fork
      capture(g, seq_m[g], BURST, 3, 1'b0, 1'b1);
      begin
        repeat (5) @(negedge clk);
        stall_a[0] = 1'b1;
        repeat (3) @(negedge clk);
        stall_a[0] = 1'b0;
      end
    join
    seq_m[g]++;
    @(negedge clk);
    chk_idle("idle_after_stall");
    chk("err_stall", 72'(err_a), 72'(0));

    // Short source: only 5 words, frame aborts after timeout.
    flush = 1'b1;
    budget_a[0] = 5;
    exp_k[0] = 0;
    @(negedge clk);
    flush = 1'b0;
    sa.I_src_req = 2'b01;
    g = pick(2'b01);
    ptr_m = (g + 1) % 2;
    @(negedge clk);
    capture(g, seq_m[g], 5, BURST + TIMEOUT - 3 - 5, 1'b1, 1'b1);
    @(negedge clk);
    chk("err_single", 72'(err_a), 72'(0));
    chk_idle("idle_after_abort");
    flush = 1'b1;
    budget_a[0] = 1000;
    exp_k[0] = 0;
    @(negedge clk);
    flush = 1'b0;

    // Sequence number unchanged by the abort.
    sa.I_src_req = 2'b01;
    g = pick(2'b01);
    ptr_m = (g + 1) % 2;
    @(negedge clk);
    capture(g, seq_m[g], BURST, 0, 1'b0, 1'b1);
    seq_m[g]++;
    @(negedge clk);

    // Reset during payload.
    sa.I_src_req = 2'b01;
    @(negedge clk);
    sa.I_src_req = 2'b00;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    exp_k[0] = 0;
    exp_k[1] = 0;
    seq_m[0] = 0;
    seq_m[1] = 0;
    ptr_m = 0;
    @(negedge clk);
    chk("mid_rst_dat", 72'(dat_a), 72'(rep(16'hC5BC)));
    chk("mid_rst_isk", 72'(k_a), 72'(8'h55));
    chk("mid_rst_busy", 72'(busy_a), 72'(0));
    chk("mid_rst_rd", 72'(sa.O_src_rd), 72'(0));
    chk("mid_rst_gid", 72'(gid_a), 72'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rd", 72'(sa.O_src_rd), 72'(0));
    sa.I_src_req = 2'b01;
    g = pick(2'b01);
    ptr_m = (g + 1) % 2;
    @(negedge clk);
    capture(g, seq_m[g], BURST, 0, 1'b0, 1'b1);
    seq_m[g]++;
    @(negedge clk);

    // Fixed priority: source 0 every frame, seq wraps on frame 257.
    sel = 1'b1;
    sb.I_src_req = 2'b11;
    @(negedge clk);
    for (int m = 0; m < 257; m++) begin
      capture(0, m % 256, BURST, 0, 1'b0, m == 256);
      if (m < 256) @(negedge clk);
    end
    @(negedge clk);
    chk_idle("idle_after_fp");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serdes_tx_framer.md
# serdes_tx_framer

Parametrised multi-source SerDes transmit framer for the 16-bit-per-lane GTX transmit path, running entirely in the transmit clock domain. It arbitrates between NSRC first-word-fall-through-free (1-cycle read latency) source FIFOs. It wraps each granted burst in a K-character header and trailer with a per-source sequence number. Between frames it drives comma/idle words on all LANES lanes. It replaces fixed two-source, fixed four-lane framing with configurable lanes, sources, burst length, arbitration mode and stall recovery.

## Interface
Parameters:
- LANES, 4, number of 16-bit SerDes lanes; payload word width = LANES*16
- NSRC, 2, number of sources, 1..16
- BURST, 8, payload words per frame, 1..255
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (source 0 highest)
- TIMEOUT, 16, cycles allowed with no I_src_valid after the last read before a frame is aborted, ≥2

Ports:
- I_sys_clk  in  1  transmit clock; all logic on its rising edge
- I_rst  in  1  reset, synchronous, active-high
- I_src_req  in  NSRC  source i holds ≥BURST words; level
- O_src_rd  out  NSRC  read enable to source i; data is returned one cycle later
- I_src_valid  in  NSRC  read data valid from source i
- I_src_dat  in  NSRC*LANES*16  source i data at bits [i*LANES*16 +: LANES*16]
- O_tx_dat  out  LANES*16  lane j at bits [16j+15:16j]
- O_tx_is_k  out  LANES*2  per-byte K flag; lane j at bits [2j+1:2j]
- O_busy  out  1  high from grant through the trailer cycle
- O_grant_id  out  4  index of the source being framed; holds the last value when idle
- O_err  out  1  one-cycle pulse on frame abort

## Operation
- All lanes carry the same control word. Words are written as {high byte, low byte}. Only the low byte is ever a K character.
- Word codes:
  - IDLE = {C5, BC}, is_k 01.
  - SOF1 = {A0|id, 3C}, is_k 01.
  - SOF2 = {seq[id], 1C}, is_k 01.
  - EOF = {BURST[7:0], 7C}, is_k 01.
  - ABORT = {cnt[7:0], 5C}, is_k 01, where cnt is the number of valid words sent.
  - Payload: is_k 00, with the source data passed straight to lanes.
- State machine: IDLE, SOF1, SOF2, PAY, EOF.
  - IDLE: emit IDLE. If any I_src_req is set, register a grant and go to SOF1.
  - SOF1: emit SOF1. Assert O_src_rd[id]. Go to SOF2.
  - SOF2: emit SOF2. Go to PAY.
  - PAY:
    - O_src_rd[id] stays high until exactly BURST reads have been issued.
    - Each I_src_valid[id] word is output in the next cycle with is_k 00, and cnt increments.
    - A cycle with no valid word outputs IDLE.
    - When cnt == BURST, go to EOF.
    - If the TIMEOUT counter expires first, output ABORT, pulse O_err, and go to EOF-exit without emitting EOF.
    - Valid words beyond BURST, and valid words from non-granted sources, are ignored.
  - EOF: emit EOF. seq[id] increments, wrapping 255 to 0; it does not increment on abort. Sample I_src_req for the next grant, so back-to-back frames have no idle gap. Otherwise go to IDLE.
- Round-robin arbitration: search starts at last_id+1 modulo NSRC. Fixed priority: lowest set index wins.
- Only a source with I_src_req set is granted. I_src_req is not rechecked after the grant.

## Timing
- All outputs are registered. Reset values: O_tx_dat = IDLE on all lanes, O_tx_is_k = 01 per lane, O_src_rd = 0, O_busy = 0, O_grant_id = 0, O_err = 0. Reset also clears all seq[] counters, cnt, the timeout counter and last_id (so the first round-robin search starts at 0).
- Frame timing, with I_src_req seen in IDLE at cycle t and a well-behaved source:
  - SOF1 output at t+1; SOF2 at t+2.
  - O_src_rd high t+1 .. t+BURST.
  - Valid words t+2 .. t+BURST+1; payload output t+3 .. t+BURST+2.
  - EOF at t+BURST+3.
  - A next-frame SOF1 is possible at t+BURST+4.
- The timeout counter clears on every valid word. It starts after the final read and expires at TIMEOUT cycles.
- Reset asserted mid-frame: the next cycle shows reset values. No trailer is emitted and no O_src_rd is issued.

## Test plan
- Reset, then NSRC=2, BURST=8, src0 req at cycle 10 with data 0x1..0x8 → SOF1 {A0,3C} at 11, SOF2 {00,1C} at 12, payload at 13..20, EOF {08,7C} at 21, then IDLE C5BC is_k 01.
- Both reqs held, ARB_MODE=0 → grants alternate 0,1,0,1. There are no IDLE cycles between an EOF and the next SOF1. SOF2 seq values are 0,0,1,1.
- ARB_MODE=1 with both reqs held → source 0 is granted every frame, and seq[0] wraps 255→0 on the 257th frame.
- src0 drops valid for 3 cycles mid-burst → 3 IDLE words inside the payload, all 8 payload words delivered, then EOF; O_err stays 0.
- src0 returns only 5 valid words, TIMEOUT=16 → ABORT {05,5C} 16 cycles after the last read, O_err is a single pulse, and seq[0] is unchanged.
- Reset asserted in PAY → next cycle all lanes IDLE, O_busy 0 and O_src_rd 0. A fresh request then yields SOF2 seq 0.
